// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit for the execute stage.
// It takes one operation at a time through a valid/ready handshake and pulses
// done_o when result_o holds the answer. Multiply runs either as one array
// multiply or as a shift-add loop. Divide is radix-2 restoring. Divide by zero
// and signed overflow skip the loop.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW   = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    state_t state, state_next;

    // Operands and flags captured at accept.
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            a_neg_q, b_neg_q, special_q;

    // Working registers for the loops.
    // Multiply: opnd_q = |a|, {hi_q, lo_q} = partial product, with the multiplier shifting out of lo_q.
    // Divide: opnd_q = |b|, hi_q = partial remainder, lo_q = dividend shifting into the quotient.
    logic [XLEN-1:0] opnd_q, hi_q, lo_q;
    logic [CW-1:0]   count_q;

    logic            accept;
    logic            a_sgn, b_sgn, a_neg, b_neg, special;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    logic [2*XLEN-1:0] prod_arr, prod_mag, prod;
    logic [XLEN-1:0]   mul_res, quo, rem, fin_result;

    // Decode the incoming request: which operands are signed, their magnitudes, and whether the divide skips the loop.
    always_comb begin
        accept  = valid_i && (state == IDLE) && !flush_i;
        a_sgn   = op_i[2] ? !op_i[0] : ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10));
        b_sgn   = op_i[2] ? !op_i[0] : (op_i[1:0] == 2'b01);
        a_neg   = a_sgn && a_i[XLEN-1];
        b_neg   = b_sgn && b_i[XLEN-1];
        a_mag   = a_neg ? -a_i : a_i;
        b_mag   = b_neg ? -b_i : b_i;
        special = (b_i == '0) || (!op_i[0] && (a_i == MIN) && (b_i == '1));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic. A flush during the loop or in FIN returns the unit to IDLE without a result.
    always_comb begin
        state_next = state;
        ready_o    = (state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!op_i[2]) state_next = (MUL_ITER != 0) ? MUL : FIN;
                    else          state_next = special ? FIN : DIV;
                end
            end
            MUL, DIV: begin
                if (flush_i)              state_next = IDLE;
                else if (count_q == LAST) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One step of shift-add multiply and one step of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
    end

    // Form the final result from the latched operands or the loop registers.
    always_comb begin
        prod_arr = {{XLEN{a_neg_q}}, a_q} * {{XLEN{b_neg_q}}, b_q};
        prod_mag = {hi_q, lo_q};
        prod     = (MUL_ITER != 0) ? ((a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag) : prod_arr;
        mul_res  = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        if (special_q) begin
            quo = (b_q == '0) ? '1 : MIN;
            rem = (b_q == '0) ? a_q : '0;
        end else begin
            quo = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
            rem = a_neg_q ? -hi_q : hi_q;
        end
        fin_result = op_q[2] ? (op_q[1] ? rem : quo) : mul_res;
    end

    // Datapath: latch at accept, step the loops, and publish the result in FIN unless flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            done_o    <= 1'b0;
            result_o  <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= op_i;
                        a_q       <= a_i;
                        b_q       <= b_i;
                        a_neg_q   <= a_neg;
                        b_neg_q   <= b_neg;
                        special_q <= op_i[2] && special;
                        opnd_q    <= op_i[2] ? b_mag : a_mag;
                        lo_q      <= op_i[2] ? a_mag : b_mag;
                        hi_q      <= '0;
                        count_q   <= '0;
                    end
                end
                MUL: begin
                    hi_q    <= mul_sum[XLEN:1];
                    lo_q    <= {mul_sum[0], lo_q[XLEN-1:1]};
                    count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
                end
                DIV: begin
                    hi_q    <= div_ge ? div_diff : div_shift[XLEN-1:0];
                    lo_q    <= {lo_q[XLEN-2:0], div_ge};
                    count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
                end
                FIN: begin
                    if (!flush_i) begin
                        result_o <= fin_result;
                        done_o   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32).
// Expected results and latencies go into a scoreboard queue when an operation is
// accepted. They are popped and compared when done_o pulses.
module tb_muldiv_unit;

    parameter int MUL_ITER = 0;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = (MUL_ITER != 0) ? XLEN + 1 : 1;
    localparam int DIV_LAT = XLEN + 1;
    localparam int BOUND   = 200;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic            clk;
    logic            reset;
    logic            valid_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            ready_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0] expQ[$];
    int              latQ[$];

    muldiv_unit #(.XLEN(XLEN), .MUL_ITER(MUL_ITER)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts a miscompare and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one request and hold it until it is accepted. When track is set, push the expected result and latency.
    task automatic applyStimulus(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] expRes, input int expLat, input bit track);
        int guard;
        @(negedge clk);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        guard   = 0;
        while (!ready_o && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= BOUND) checkOutput("accept_timeout", ready_o, 1);
        @(posedge clk);
        if (track) begin
            expQ.push_back(expRes);
            latQ.push_back(expLat);
        end
        #1 valid_i = 1'b0;
    endtask

    // Wait, with a bound, for done_o, then check latency and result against the scoreboard head.
    task automatic waitResult(input string tag);
        int              cycles;
        int              qs;
        logic            seen;
        logic [XLEN-1:0] expRes;
        int              expLat;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < BOUND) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = done_o;
        end
        checkOutput({tag, "_done"}, seen, 1);
        qs = expQ.size();
        checkOutput({tag, "_queued"}, (qs != 0), 1);
        if (qs != 0) begin
            expRes = expQ.pop_front();
            expLat = latQ.pop_front();
            checkOutput({tag, "_latency"}, cycles, expLat);
            checkOutput({tag, "_result"}, result_o, expRes);
        end
    endtask

    // Watch for n cycles and require that done_o never pulses.
    task automatic expectQuiet(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done_o) hits++;
        end
        checkOutput(tag, hits, 0);
    endtask

    // Directed sequence.
    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        #12;
        checkOutput("reset_ready", ready_o, 1);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_result", result_o, 0);
        @(negedge clk);
        reset = 1'b0;

        // Multiplies.
        applyStimulus(OP_MUL, 32'd7, -32'sd3, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
        waitResult("mul_7x-3");
        applyStimulus(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b1);
        waitResult("mulh_min_min");
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b1);
        waitResult("mulhu_max");
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
        waitResult("mulhsu_-1");

        // Normal divides.
        applyStimulus(OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        waitResult("div_-7_2");
        applyStimulus(OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 1'b1);
        waitResult("rem_-7_2");
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b1);
        waitResult("divu_100_7");
        applyStimulus(OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 1'b1);
        waitResult("remu_100_7");

        // Divide by zero bypasses the loop.
        applyStimulus(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        waitResult("divu_5_0");
        applyStimulus(OP_REM, 32'd5, 32'd0, 32'd5, 1, 1'b1);
        waitResult("rem_5_0");

        // Flush a divide in flight: back to idle, no pulse, old result kept.
        applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("flush_busy", ready_o, 0);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        checkOutput("flush_ready", ready_o, 1);
        checkOutput("flush_done", done_o, 0);
        checkOutput("flush_result_kept", result_o, 5);
        expectQuiet("flush_no_done", 40);
        applyStimulus(OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, 1'b1);
        waitResult("mul_3x4");
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done_o, 0);
        checkOutput("result_held", result_o, 12);

        // Signed overflow bypass.
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        waitResult("div_ovf");
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        waitResult("rem_ovf");

        // Flush in IDLE wins over valid_i.
        @(negedge clk);
        op_i    = OP_MUL;
        a_i     = 32'd9;
        b_i     = 32'd9;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_flush_ready", ready_o, 1);
        valid_i = 1'b0;
        flush_i = 1'b0;
        expectQuiet("idle_flush_no_done", 5);

        // valid_i held with operands changed mid-operation; the second op is accepted right after done_o.
        @(negedge clk);
        op_i    = OP_DIVU;
        a_i     = 32'd100;
        b_i     = 32'd7;
        valid_i = 1'b1;
        @(posedge clk);
        expQ.push_back(32'd14);
        latQ.push_back(DIV_LAT);
        #1;
        op_i = OP_MUL;
        a_i  = 32'd3;
        b_i  = 32'd5;
        waitResult("hold_first");
        expQ.push_back(32'd15);
        latQ.push_back(MUL_LAT);
        @(posedge clk);
        #1;
        checkOutput("hold_second_accepted", ready_o, 0);
        valid_i = 1'b0;
        waitResult("hold_second");

        // Async reset mid-divide takes effect before the next clock edge.
        applyStimulus(OP_DIV, -32'sd7, 32'd2, 32'd0, 0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_ready", ready_o, 1);
        checkOutput("async_reset_done", done_o, 0);
        checkOutput("async_reset_result", result_o, 0);
        @(negedge clk);
        reset = 1'b0;
        expectQuiet("after_reset_no_done", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
